reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
// - Write-side master for the two-read/one-write registers bank: buffers results (ALU/memory) in an in-order FIFO.
// - Drains one entry per cycle onto the bank write port (addr_R / write_reg / write_data).
// - Forwards pending (not yet committed) data to the read side so operand fetch never sees stale registers.
// PARAMETERS
// - size_reg  16  data width, equals bank register width
// - addr_reg  2   register address width (2**addr_reg registers)
// - DEPTH     4   FIFO entries; power of 2, >=2
// PORTS
// - clock        in   1         single clock, rising edge
// - reset        in   1         synchronous, active-high
// - res_valid    in   1         result offered
// - res_ready    out  1         queue can accept
// - res_addr     in   addr_reg  destination register of result
// - res_data     in   size_reg  result value
// - wb_hold      in   1         1 = do not issue a write this cycle
// - addr_R       out  addr_reg  to bank addr_R (registered)
// - write_reg    out  1         to bank write_reg (registered)
// - write_data   out  size_reg  to bank write_data (registered)
// - look_addr_A  in   addr_reg  same value as bank addr_A
// - look_addr_B  in   addr_reg  same value as bank addr_B
// - fwd_hit_A/B  out  1         pending write targets look_addr_A/B
// - fwd_data_A/B out  size_reg  newest pending value for that address
// - pending_cnt  out  clog2(DEPTH+1)  entries in FIFO
// BEHAVIOUR
// - Reset (clock edge with reset=1): count=0, rd/wr ptr=0, addr_R=0, write_reg=0, write_data=0, FSM=IDLE.
// - res_ready = !reset && (count<DEPTH); combinational from count only, never from res_valid or wb_hold.
// - Push: res_valid&&res_ready at edge -> entry {res_addr,res_data} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
// - Pop: at edge with count>0 && !wb_hold -> addr_R/write_data <= head, write_reg <= 1, rd_ptr++ (wraps).
// - Otherwise write_reg <= 0; addr_R/write_data hold last values.
// - Latency: push at edge N into empty queue -> write_reg=1 during cycle N+1 -> bank commits at edge N+2.
// - Push and pop in the same edge: count unchanged. When full, ready=0, so no push; a pop that edge frees a slot next cycle.
// - Duplicate addresses are allowed; writes issue strictly in push order, so the last one wins in the bank.
// - FSM (status/debug): IDLE (count==0), DRAIN (count>0 && !wb_hold), HELD (count>0 && wb_hold).
// - FSM recomputed every edge from next-state count and wb_hold.
// - Reset mid-drain: queue contents discarded, write_reg=0 next cycle; no partial write is issued.
// - Forwarding candidates:
//   - the output register while write_reg=1 (data not yet in bank);
//   - all valid FIFO entries.
// - Forwarding priority: newest FIFO entry matching the address wins; the output register is lowest priority.
// - Forwarding is combinational, same cycle as look_addr.
// - No match: fwd_hit=0, fwd_data=0.
// - Consumer muxes fwd_data over bank data_A/data_B when fwd_hit=1.
// CONFIGURATION
// - WB_FORWARD_EN defined: forwarding logic as above.
// - WB_FORWARD_EN undefined:
//   - fwd_hit_A/B=0 and fwd_data_A/B=0 constant; ports remain;
//   - consumer must stall while pending_cnt!=0 or write_reg=1.
// TESTING
// - Reset 2 cycles -> write_reg=0, addr_R=0, write_data=0, pending_cnt=0, res_ready=1 after deassert.
// - Push (2,16'h00A5) at edge N, wb_hold=0 -> write_reg=1, addr_R=2, write_data=00A5 in cycle N+1; next cycle read reg2=00A5.
// - wb_hold=1, push 4 results -> res_ready=0, 5th valid ignored.
//   - Then release hold -> 4 consecutive writes, in order, res_ready=1 after first pop.
// - Push (1,0x1111) then (1,0x2222), hold, look_addr_A=1 -> fwd_hit_A=1, fwd_data_A=0x2222; look_addr_B=3 -> fwd_hit_B=0.
// - Full queue, hold released with res_valid held high -> push accepted the cycle after each pop.
//   - pending_cnt stays <=4; rd/wr ptr wrap covered.
// - Reset asserted while 3 entries pending and write_reg=1 -> next cycle write_reg=0, pending_cnt=0, no further writes.

Source files
------------

// File: rtl/reg_writeback_queue_if.sv
// Result-in / bank-write-out / forwarding bundle for reg_writeback_queue.
// The master modport is the queue itself; the slave modport is its producer/bank/operand-fetch side.
interface reg_writeback_queue_if #(
   parameter int unsigned size_reg = 16,
   parameter int unsigned addr_reg = 2,
   parameter int unsigned DEPTH    = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic                res_valid;
   logic                res_ready;
   logic [addr_reg-1:0] res_addr;
   logic [size_reg-1:0] res_data;
   logic                wb_hold;
   logic [addr_reg-1:0] addr_R;
   logic                write_reg;
   logic [size_reg-1:0] write_data;
   logic [addr_reg-1:0] look_addr_A;
   logic [addr_reg-1:0] look_addr_B;
   logic                fwd_hit_A;
   logic                fwd_hit_B;
   logic [size_reg-1:0] fwd_data_A;
   logic [size_reg-1:0] fwd_data_B;
   logic [CW-1:0]       pending_cnt;
   // Status: 0 = IDLE, 1 = DRAIN, 2 = HELD.
   logic [1:0]          wb_state;

   modport master (
      input  res_valid, res_addr, res_data, wb_hold, look_addr_A, look_addr_B,
      output res_ready, addr_R, write_reg, write_data,
             fwd_hit_A, fwd_hit_B, fwd_data_A, fwd_data_B, pending_cnt, wb_state
   );

   modport slave (
      output res_valid, res_addr, res_data, wb_hold, look_addr_A, look_addr_B,
      input  res_ready, addr_R, write_reg, write_data,
             fwd_hit_A, fwd_hit_B, fwd_data_A, fwd_data_B, pending_cnt, wb_state
   );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO that drains one result per cycle into the register bank write port.
// Define WB_FORWARD_EN to forward pending writes to the read side; otherwise fwd_* outputs are tied to 0.
module reg_writeback_queue #(
   parameter int unsigned size_reg = 16,
   parameter int unsigned addr_reg = 2,
   parameter int unsigned DEPTH    = 4
) (
   input logic                   clock,
   input logic                   reset,
   reg_writeback_queue_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, HELD = 2'd2} state_t;

   state_t              state;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_next;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [addr_reg-1:0] mem_addr [DEPTH];
   logic [size_reg-1:0] mem_data [DEPTH];
   logic [addr_reg-1:0] addr_q;
   logic [size_reg-1:0] data_q;
   logic                wr_q;
   logic                ready;
   logic                push;
   logic                pop;

   assign ready = !reset && (count < CW'(DEPTH));
   assign push  = bus.res_valid && ready;
   assign pop   = (count != '0) && !bus.wb_hold;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Payload storage needs no reset: only entries below count are ever observed.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_addr[wr_ptr] <= bus.res_addr;
         mem_data[wr_ptr] <= bus.res_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         addr_q <= '0;
         data_q <= '0;
         wr_q   <= 1'b0;
         state  <= IDLE;
      end else begin
         count <= count_next;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            addr_q <= mem_addr[rd_ptr];
            data_q <= mem_data[rd_ptr];
            wr_q   <= 1'b1;
         end else begin
            wr_q   <= 1'b0;
         end
         if (count_next == '0)  state <= IDLE;
         else if (bus.wb_hold)  state <= HELD;
         else                   state <= DRAIN;
      end
   end

   assign bus.res_ready   = ready;
   assign bus.addr_R      = addr_q;
   assign bus.write_reg   = wr_q;
   assign bus.write_data  = data_q;
   assign bus.pending_cnt = count;
   assign bus.wb_state    = state;

`ifdef WB_FORWARD_EN
   logic [addr_reg-1:0] look [2];
   logic                hit  [2];
   logic [size_reg-1:0] fwd  [2];

   always_comb begin
      look[0] = bus.look_addr_A;
      look[1] = bus.look_addr_B;
      for (int p = 0; p < 2; p++) begin
         hit[p] = 1'b0;
         fwd[p] = '0;
         if (wr_q && (addr_q == look[p])) begin
            hit[p] = 1'b1;
            fwd[p] = data_q;
         end
         // Scan oldest to newest so the newest matching entry overrides.
         for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CW'(i) < count) && (mem_addr[rd_ptr + PW'(i)] == look[p])) begin
               hit[p] = 1'b1;
               fwd[p] = mem_data[rd_ptr + PW'(i)];
            end
         end
      end
   end

   assign bus.fwd_hit_A  = hit[0];
   assign bus.fwd_hit_B  = hit[1];
   assign bus.fwd_data_A = fwd[0];
   assign bus.fwd_data_B = fwd[1];
`else
   logic unused_look;
   assign unused_look    = ^{bus.look_addr_A, bus.look_addr_B};
   assign bus.fwd_hit_A  = 1'b0;
   assign bus.fwd_hit_B  = 1'b0;
   assign bus.fwd_data_A = '0;
   assign bus.fwd_data_B = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vector table, then random traffic against a queue-based model.
module tb_reg_writeback_queue;
   localparam int unsigned SW = 16;
   localparam int unsigned AW = 2;
   localparam int unsigned DEPTH = 4;
`ifdef WB_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   typedef struct {
      logic          rst;
      logic          valid;
      logic [AW-1:0] addr;
      logic [SW-1:0] data;
      logic          hold;
      logic [AW-1:0] la;
      logic [AW-1:0] lb;
      logic          chk_fwd;
      logic          e_ready;
      logic          e_hit_a;
      logic [SW-1:0] e_fd_a;
      logic          e_hit_b;
      logic [SW-1:0] e_fd_b;
      logic          e_wr;
      logic [AW-1:0] e_addr;
      logic [SW-1:0] e_data;
      logic [2:0]    e_cnt;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [SW-1:0] d;
   } ent_t;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   ent_t          mq[$];
   logic          m_wr = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [SW-1:0] m_data = '0;
   logic [1:0]    m_state = 2'd0;
   bit            m_init = 1'b0;

   vec_t vecs[$];

   always #5 clock = ~clock;

   reg_writeback_queue_if #(.size_reg(SW), .addr_reg(AW), .DEPTH(DEPTH)) bus ();

   reg_writeback_queue #(.size_reg(SW), .addr_reg(AW), .DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   // Newest pending write for address a: queue back wins, then the issued write.
   function automatic void model_fwd(input logic [AW-1:0] a, output logic h, output logic [SW-1:0] d);
      h = 1'b0;
      d = '0;
      if (m_wr && m_addr == a) begin
         h = 1'b1;
         d = m_data;
      end
      foreach (mq[i]) begin
         if (mq[i].a == a) begin
            h = 1'b1;
            d = mq[i].d;
         end
      end
      if (!FWD_EN) begin
         h = 1'b0;
         d = '0;
      end
   endfunction

   task automatic model_edge(input vec_t v);
      bit   rdy;
      ent_t e;
      if (v.rst) begin
         mq.delete();
         m_wr = 1'b0;
         m_addr = '0;
         m_data = '0;
         m_init = 1'b1;
      end else begin
         rdy = (mq.size() < DEPTH);
         if (mq.size() > 0 && !v.hold) begin
            e = mq.pop_front();
            m_wr = 1'b1;
            m_addr = e.a;
            m_data = e.d;
         end else begin
            m_wr = 1'b0;
         end
         if (v.valid && rdy) mq.push_back('{v.addr, v.data});
      end
      m_state = (mq.size() == 0) ? 2'd0 : (v.hold && !v.rst) ? 2'd2 : 2'd1;
   endtask

   task automatic do_cycle(input vec_t v, input bit use_tab, input int idx);
      logic          h;
      logic [SW-1:0] d;
      reset           = v.rst;
      bus.res_valid   = v.valid;
      bus.res_addr    = v.addr;
      bus.res_data    = v.data;
      bus.wb_hold     = v.hold;
      bus.look_addr_A = v.la;
      bus.look_addr_B = v.lb;
      #1;
      check("res_ready", idx, 32'(bus.res_ready), 32'(!v.rst && (mq.size() < DEPTH)));
      if (m_init) begin
         model_fwd(v.la, h, d);
         check("fwd_A", idx, {15'd0, bus.fwd_hit_A, bus.fwd_data_A}, {15'd0, h, d});
         model_fwd(v.lb, h, d);
         check("fwd_B", idx, {15'd0, bus.fwd_hit_B, bus.fwd_data_B}, {15'd0, h, d});
      end
      if (use_tab) begin
         check("tab_ready", idx, 32'(bus.res_ready), 32'(v.e_ready));
         if (v.chk_fwd) begin
            check("tab_fwd_A", idx, {15'd0, bus.fwd_hit_A, bus.fwd_data_A},
                  FWD_EN ? {15'd0, v.e_hit_a, v.e_fd_a} : 32'd0);
            check("tab_fwd_B", idx, {15'd0, bus.fwd_hit_B, bus.fwd_data_B},
                  FWD_EN ? {15'd0, v.e_hit_b, v.e_fd_b} : 32'd0);
         end
      end
      @(posedge clock);
      model_edge(v);
      #1;
      check("write_port", idx, {13'd0, bus.write_reg, bus.addr_R, bus.write_data},
            {13'd0, m_wr, m_addr, m_data});
      check("pending_cnt", idx, 32'(bus.pending_cnt), 32'(mq.size()));
      check("wb_state", idx, 32'(bus.wb_state), 32'(m_state));
      if (use_tab) begin
         check("tab_write_port", idx, {13'd0, bus.write_reg, bus.addr_R, bus.write_data},
               {13'd0, v.e_wr, v.e_addr, v.e_data});
         check("tab_pending_cnt", idx, 32'(bus.pending_cnt), 32'(v.e_cnt));
      end
   endtask

   initial begin
      vec_t v;
      bit   hold_bias;
      // '{rst,valid,addr,data,hold,la,lb, chk,rdy,hitA,fdA,hitB,fdB, wr,addr_R,write_data,cnt}
      vecs.push_back('{1,0,0,16'h0000,0,0,0, 0,0,0,16'h0,0,16'h0, 0,0,16'h0000,0});
      vecs.push_back('{1,0,0,16'h0000,0,0,0, 0,0,0,16'h0,0,16'h0, 0,0,16'h0000,0});
      vecs.push_back('{0,1,2,16'h00A5,0,0,0, 0,1,0,16'h0,0,16'h0, 0,0,16'h0000,1});
      vecs.push_back('{0,0,0,16'h0000,0,2,0, 1,1,1,16'h00A5,0,16'h0, 1,2,16'h00A5,0});
      vecs.push_back('{0,0,0,16'h0000,0,2,0, 1,1,1,16'h00A5,0,16'h0, 0,2,16'h00A5,0});
      vecs.push_back('{0,0,0,16'h0000,0,2,0, 1,1,0,16'h0,0,16'h0, 0,2,16'h00A5,0});
      vecs.push_back('{0,1,0,16'h1000,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h00A5,1});
      vecs.push_back('{0,1,1,16'h1001,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h00A5,2});
      vecs.push_back('{0,1,2,16'h1002,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h00A5,3});
      vecs.push_back('{0,1,3,16'h1003,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h00A5,4});
      vecs.push_back('{0,1,0,16'hBAD0,1,3,1, 1,0,1,16'h1003,1,16'h1001, 0,2,16'h00A5,4});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,0,0,16'h0,0,16'h0, 1,0,16'h1000,3});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 1,1,16'h1001,2});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 1,2,16'h1002,1});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 1,3,16'h1003,0});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 0,3,16'h1003,0});
      vecs.push_back('{0,1,1,16'h1111,1,0,0, 0,1,0,16'h0,0,16'h0, 0,3,16'h1003,1});
      vecs.push_back('{0,1,1,16'h2222,1,0,0, 0,1,0,16'h0,0,16'h0, 0,3,16'h1003,2});
      vecs.push_back('{0,0,0,16'h0000,1,1,3, 1,1,1,16'h2222,0,16'h0, 0,3,16'h1003,2});
      vecs.push_back('{0,0,0,16'h0000,0,1,3, 1,1,1,16'h2222,0,16'h0, 1,1,16'h1111,1});
      vecs.push_back('{0,0,0,16'h0000,0,1,3, 1,1,1,16'h2222,0,16'h0, 1,1,16'h2222,0});
      vecs.push_back('{0,0,0,16'h0000,0,1,3, 1,1,1,16'h2222,0,16'h0, 0,1,16'h2222,0});
      vecs.push_back('{0,1,0,16'h3000,1,0,0, 0,1,0,16'h0,0,16'h0, 0,1,16'h2222,1});
      vecs.push_back('{0,1,1,16'h3001,1,0,0, 0,1,0,16'h0,0,16'h0, 0,1,16'h2222,2});
      vecs.push_back('{0,1,2,16'h3002,1,0,0, 0,1,0,16'h0,0,16'h0, 0,1,16'h2222,3});
      vecs.push_back('{0,1,3,16'h3003,1,0,0, 0,1,0,16'h0,0,16'h0, 0,1,16'h2222,4});
      vecs.push_back('{0,1,0,16'h3004,0,0,0, 0,0,0,16'h0,0,16'h0, 1,0,16'h3000,3});
      vecs.push_back('{0,1,1,16'h3004,0,0,0, 0,1,0,16'h0,0,16'h0, 1,1,16'h3001,3});
      vecs.push_back('{0,1,2,16'h3005,0,0,0, 0,1,0,16'h0,0,16'h0, 1,2,16'h3002,3});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 1,3,16'h3003,2});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 1,1,16'h3004,1});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 1,2,16'h3005,0});
      vecs.push_back('{0,1,0,16'h4000,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h3005,1});
      vecs.push_back('{0,1,1,16'h4001,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h3005,2});
      vecs.push_back('{0,1,2,16'h4002,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h3005,3});
      vecs.push_back('{0,1,3,16'h4003,1,0,0, 0,1,0,16'h0,0,16'h0, 0,2,16'h3005,4});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,0,0,16'h0,0,16'h0, 1,0,16'h4000,3});
      vecs.push_back('{1,1,1,16'h5555,0,0,0, 0,0,0,16'h0,0,16'h0, 0,0,16'h0000,0});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 0,0,16'h0000,0});
      vecs.push_back('{0,0,0,16'h0000,0,0,0, 0,1,0,16'h0,0,16'h0, 0,0,16'h0000,0});

      reset = 1'b1;
      bus.res_valid = 1'b0;
      bus.res_addr = '0;
      bus.res_data = '0;
      bus.wb_hold = 1'b0;
      bus.look_addr_A = '0;
      bus.look_addr_B = '0;
      @(posedge clock);
      #1;

      foreach (vecs[i]) do_cycle(vecs[i], 1'b1, i);

      hold_bias = 1'b0;
      for (int n = 0; n < 800; n++) begin
         v = '{default: '0};
         if ($urandom_range(0, 15) == 0) hold_bias = ~hold_bias;
         v.rst   = ($urandom_range(0, 99) == 0);
         v.valid = ($urandom_range(0, 3) != 0);
         v.addr  = AW'($urandom);
         v.data  = SW'($urandom);
         v.hold  = hold_bias ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 4) == 0);
         v.la    = AW'($urandom);
         v.lb    = AW'($urandom);
         do_cycle(v, 1'b0, 1000 + n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
